mini_dmem_arbiter: RTL and testbench

- Shares the mini core's single-port data memory between two requesters: the core load/store stage (Q103H) and an external port used by the debug/loader.
- Performs per-cycle arbitration with core-default priority and a starvation limit, and supports an ext burst lock.
- Rejects accesses outside the D_MEM region.
- Routes the 1-cycle-latency read data back to whichever requester issued the read.
- Sits between the core memory stage and the D_MEM instance.

---
 rtl/mini_core_pkg.sv | 47 ++++
 rtl/mini_dmem_rd_route.sv | 56 +++++
 rtl/mini_dmem_arbiter.sv | 124 ++++++++++++
 tb/tb_mini_dmem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mini_core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mini_core_pkg
// Description : Shared types and constants for the mini core memory system:
//               core-to-memory request payload, D_MEM region bounds and the
//               data-memory arbiter owner/state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package mini_core_pkg;

  // Address region decode: the region field is Address[MSB:LSB]
  localparam int unsigned LSB_REGION_MINI = 16;
  localparam int unsigned MSB_REGION_MINI = 31;
  localparam int unsigned REGION_W_MINI   = MSB_REGION_MINI - LSB_REGION_MINI + 1;

  // D_MEM occupies 0x0001_0000 .. 0x0001_FFFF
  localparam logic [REGION_W_MINI-1:0] D_MEM_REGION_FLOOR_MINI = 16'h0001;
  localparam logic [REGION_W_MINI-1:0] D_MEM_REGION_ROOF_MINI  = 16'h0001;

  // Default ext starvation limit for the data-memory arbiter
  localparam int unsigned EXT_MAX_WAIT_DFLT = 4;

  typedef struct packed {
    logic [31:0] Address;
    logic [31:0] WrData;
    logic [3:0]  ByteEn;
    logic        WrEn;
    logic        RdEn;
  } t_core2mem_req;

  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_EXT  = 1'b1
  } t_dmem_owner;

  typedef enum logic {
    ARB_CORE     = 1'b0,
    ARB_EXT_LOCK = 1'b1
  } t_dmem_arb_state;

  // True when the region field falls inside the D_MEM window
  function automatic logic in_dmem_region(input logic [REGION_W_MINI-1:0] region);
    return (region >= D_MEM_REGION_FLOOR_MINI) && (region <= D_MEM_REGION_ROOF_MINI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mini_dmem_rd_route.sv
`default_nettype none
// ============================================================================
// Module      : mini_dmem_rd_route
// Description : Tracks the single outstanding D_MEM read and steers the
//               returned data to the requester that issued it. Each
//               requester's data output holds its last delivered value.
// Revision    : 1.0 - initial release
// ============================================================================
module mini_dmem_rd_route
  import mini_core_pkg::*;
(
  input  logic        clock,
  input  logic        rst,
  input  logic        rd_issue,
  input  t_dmem_owner rd_owner,
  input  logic        rd_reject,
  input  logic [31:0] mem_rd_data,
  output logic [31:0] core_rd_data,
  output logic        core_rd_valid,
  output logic [31:0] ext_rd_data,
  output logic        ext_rd_valid
);

  logic        pend;
  t_dmem_owner owner;
  logic        reject;
  logic [31:0] core_hold;
  logic [31:0] ext_hold;
  logic [31:0] ret_data;

  // Rejected reads complete on schedule but carry zero data
  assign ret_data      = reject ? 32'h0 : mem_rd_data;
  assign core_rd_valid = pend && (owner == OWNER_CORE);
  assign ext_rd_valid  = pend && (owner == OWNER_EXT);
  assign core_rd_data  = core_rd_valid ? ret_data : core_hold;
  assign ext_rd_data   = ext_rd_valid  ? ret_data : ext_hold;

  // Pending-read tag register and per-owner data hold registers
  always_ff @(posedge clock) begin
    if (rst) begin
      pend      <= 1'b0;
      owner     <= OWNER_CORE;
      reject    <= 1'b0;
      core_hold <= 32'h0;
      ext_hold  <= 32'h0;
    end else begin
      pend   <= rd_issue;
      owner  <= rd_owner;
      reject <= rd_reject;
      if (core_rd_valid) core_hold <= ret_data;
      if (ext_rd_valid)  ext_hold  <= ret_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mini_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mini_dmem_arbiter
// Description : Shares the single-port D_MEM between the core load/store
//               stage and an external (debug/loader) port. Core has default
//               priority, ext is force-granted after EXT_MAX_WAIT waits, and
//               ext may lock the memory for bursts. Out-of-region accesses
//               are masked and recorded in a sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mini_dmem_arbiter
  import mini_core_pkg::*;
#(
  parameter int unsigned EXT_MAX_WAIT = EXT_MAX_WAIT_DFLT,
  // Must be wide enough to hold EXT_MAX_WAIT
  parameter int unsigned WAIT_CNT_W   = 3
) (
  input  logic          Clock,
  input  logic          Rst,
  input  t_core2mem_req CoreReqQ103H,
  output logic          CoreStall,
  output logic [31:0]   CoreRdDataQ104H,
  output logic          CoreRdValidQ104H,
  input  logic          ExtReqValid,
  input  t_core2mem_req ExtReq,
  input  logic          ExtLock,
  output logic          ExtReady,
  output logic [31:0]   ExtRdData,
  output logic          ExtRdValid,
  output t_core2mem_req MemReq,
  input  logic [31:0]   MemRdData,
  output logic          AccessErr,
  output logic [31:0]   ErrAddr
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(EXT_MAX_WAIT);

  t_dmem_arb_state       state, state_nxt;
  logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic                  core_valid;
  logic                  core_gnt;
  logic                  ext_gnt;
  t_core2mem_req         gnt_req;
  logic                  gnt_access;
  logic                  gnt_in_region;
  t_dmem_owner           gnt_owner;

  assign core_valid = CoreReqQ103H.WrEn | CoreReqQ103H.RdEn;

  // Grant selection, next lock state and ext wait counter
  always_comb begin
    core_gnt     = 1'b0;
    ext_gnt      = 1'b0;
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    if ((state == ARB_EXT_LOCK) && ExtLock) begin
      ext_gnt = ExtReqValid;
    end else begin
      // Lock released (or never held): normal core-priority arbitration
      state_nxt = ARB_CORE;
      if (core_valid && ExtReqValid) begin
        if (wait_cnt >= WAIT_LIMIT) ext_gnt  = 1'b1;
        else                        core_gnt = 1'b1;
      end else if (core_valid) begin
        core_gnt = 1'b1;
      end else if (ExtReqValid) begin
        ext_gnt = 1'b1;
      end
      if (ext_gnt && ExtLock) state_nxt = ARB_EXT_LOCK;
    end
    if (!ExtReqValid || ext_gnt)     wait_cnt_nxt = '0;
    else if (wait_cnt < WAIT_LIMIT)  wait_cnt_nxt = wait_cnt + WAIT_CNT_W'(1);
  end

  // Route the winner's payload to memory, masking strobes outside D_MEM
  always_comb begin
    gnt_req = '0;
    if (core_gnt)     gnt_req = CoreReqQ103H;
    else if (ext_gnt) gnt_req = ExtReq;
    gnt_owner     = ext_gnt ? OWNER_EXT : OWNER_CORE;
    gnt_access    = gnt_req.WrEn | gnt_req.RdEn;
    gnt_in_region = in_dmem_region(gnt_req.Address[MSB_REGION_MINI:LSB_REGION_MINI]);
    MemReq        = gnt_req;
    if (!gnt_in_region) begin
      MemReq.WrEn = 1'b0;
      MemReq.RdEn = 1'b0;
    end
  end

  assign CoreStall = core_valid & ~core_gnt;
  assign ExtReady  = ext_gnt;

  // Arbiter state, wait counter and sticky first-error capture
  always_ff @(posedge Clock) begin
    if (Rst) begin
      state     <= ARB_CORE;
      wait_cnt  <= '0;
      AccessErr <= 1'b0;
      ErrAddr   <= 32'h0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (gnt_access && !gnt_in_region) begin
        AccessErr <= 1'b1;
        if (!AccessErr) ErrAddr <= gnt_req.Address;
      end
    end
  end

  mini_dmem_rd_route u_rd_route (
    .clock         (Clock),
    .rst           (Rst),
    .rd_issue      (gnt_req.RdEn),
    .rd_owner      (gnt_owner),
    .rd_reject     (~gnt_in_region),
    .mem_rd_data   (MemRdData),
    .core_rd_data  (CoreRdDataQ104H),
    .core_rd_valid (CoreRdValidQ104H),
    .ext_rd_data   (ExtRdData),
    .ext_rd_valid  (ExtRdValid)
  );

endmodule
`default_nettype wire

// File: tb/tb_mini_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mini_dmem_arbiter
// Description : Self-checking bench for mini_dmem_arbiter: directed scenarios
//               followed by constrained-random traffic compared against a
//               rule-level reference model of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mini_dmem_arbiter;
  import mini_core_pkg::*;

  localparam int MAX_WAIT = 4;
  localparam int W_NONE = 0, W_CORE = 1, W_EXT = 2;

  logic          Clock = 1'b0;
  logic          Rst;
  t_core2mem_req CoreReqQ103H;
  logic          CoreStall;
  logic [31:0]   CoreRdDataQ104H;
  logic          CoreRdValidQ104H;
  logic          ExtReqValid;
  t_core2mem_req ExtReq;
  logic          ExtLock;
  logic          ExtReady;
  logic [31:0]   ExtRdData;
  logic          ExtRdValid;
  t_core2mem_req MemReq;
  logic [31:0]   MemRdData;
  logic          AccessErr;
  logic [31:0]   ErrAddr;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit            m_locked;
  int            m_wait;
  bit            m_pend;
  int            m_owner;
  bit            m_prej;
  logic [31:0]   m_hold_core, m_hold_ext;
  bit            m_err;
  logic [31:0]   m_erraddr;
  int            m_win;
  t_core2mem_req m_g;
  bit            m_ok;
  logic [31:0]   m_core_data, m_ext_data;
  bit            m_core_v, m_ext_v;

  mini_dmem_arbiter #(.EXT_MAX_WAIT(4), .WAIT_CNT_W(3)) dut (
    .Clock            (Clock),
    .Rst              (Rst),
    .CoreReqQ103H     (CoreReqQ103H),
    .CoreStall        (CoreStall),
    .CoreRdDataQ104H  (CoreRdDataQ104H),
    .CoreRdValidQ104H (CoreRdValidQ104H),
    .ExtReqValid      (ExtReqValid),
    .ExtReq           (ExtReq),
    .ExtLock          (ExtLock),
    .ExtReady         (ExtReady),
    .ExtRdData        (ExtRdData),
    .ExtRdValid       (ExtRdValid),
    .MemReq           (MemReq),
    .MemRdData        (MemRdData),
    .AccessErr        (AccessErr),
    .ErrAddr          (ErrAddr)
  );

  always #5 Clock = ~Clock;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic t_core2mem_req mk(input bit wr, input bit rd, input logic [31:0] a,
                                       input logic [31:0] d);
    t_core2mem_req r;
    r.Address = a;
    r.WrData  = d;
    r.ByteEn  = 4'hF;
    r.WrEn    = wr;
    r.RdEn    = rd;
    return r;
  endfunction

  function automatic bit addr_ok(input logic [31:0] a);
    return (a >= 32'h0001_0000) && (a <= 32'h0001_FFFF);
  endfunction

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return {16'h0002, 14'($urandom), 2'b00};
    if (r == 1) return {16'h0000, 14'($urandom), 2'b00};
    return {16'h0001, 14'($urandom), 2'b00};
  endfunction

  task automatic model_reset();
    m_locked = 0; m_wait = 0; m_pend = 0; m_owner = W_CORE; m_prej = 0;
    m_hold_core = '0; m_hold_ext = '0; m_err = 0; m_erraddr = '0;
  endtask

  // Let inputs settle, compute what the arbiter must do, compare every output
  task automatic settle();
    bit cv, ev;
    t_core2mem_req er;
    #2;
    cv = CoreReqQ103H.WrEn | CoreReqQ103H.RdEn;
    ev = ExtReqValid;
    if (m_locked && ExtLock)  m_win = ev ? W_EXT : W_NONE;
    else if (cv && ev)        m_win = (m_wait >= MAX_WAIT) ? W_EXT : W_CORE;
    else if (cv)              m_win = W_CORE;
    else if (ev)              m_win = W_EXT;
    else                      m_win = W_NONE;
    m_g = '0;
    if (m_win == W_CORE) m_g = CoreReqQ103H;
    if (m_win == W_EXT)  m_g = ExtReq;
    m_ok = addr_ok(m_g.Address);
    er = m_g;
    if (!m_ok) begin er.WrEn = 1'b0; er.RdEn = 1'b0; end
    m_core_v    = m_pend && (m_owner == W_CORE);
    m_ext_v     = m_pend && (m_owner == W_EXT);
    m_core_data = m_core_v ? (m_prej ? 32'h0 : MemRdData) : m_hold_core;
    m_ext_data  = m_ext_v  ? (m_prej ? 32'h0 : MemRdData) : m_hold_ext;
    check("core_stall", 128'(CoreStall), 128'(cv && (m_win != W_CORE)));
    check("ext_ready",  128'(ExtReady),  128'(m_win == W_EXT));
    check("mem_req",    128'(MemReq),    128'(er));
    check("core_rd_v",  128'(CoreRdValidQ104H), 128'(m_core_v));
    check("core_rd_d",  128'(CoreRdDataQ104H),  128'(m_core_data));
    check("ext_rd_v",   128'(ExtRdValid), 128'(m_ext_v));
    check("ext_rd_d",   128'(ExtRdData),  128'(m_ext_data));
    check("access_err", 128'(AccessErr),  128'(m_err));
    check("err_addr",   128'(ErrAddr),    128'(m_erraddr));
  endtask

  // Advance the model across the clock edge, then return at the falling edge
  task automatic tick();
    @(posedge Clock);
    if (Rst) begin
      model_reset();
    end else begin
      if (m_core_v) m_hold_core = m_core_data;
      if (m_ext_v)  m_hold_ext  = m_ext_data;
      m_locked = (m_locked && ExtLock) || (m_win == W_EXT && ExtLock);
      m_wait   = (ExtReqValid && m_win != W_EXT) ? m_wait + 1 : 0;
      m_pend   = m_g.RdEn;
      m_owner  = (m_win == W_EXT) ? W_EXT : W_CORE;
      m_prej   = !m_ok;
      if ((m_g.WrEn || m_g.RdEn) && !m_ok) begin
        if (!m_err) m_erraddr = m_g.Address;
        m_err = 1;
      end
    end
    @(negedge Clock);
  endtask

  task automatic idle_inputs();
    CoreReqQ103H = '0; ExtReqValid = 0; ExtReq = '0; ExtLock = 0;
  endtask

  initial begin
    bit core_hold, ext_hold;
    Rst = 1; idle_inputs(); MemRdData = '0;
    model_reset();
    @(negedge Clock);
    repeat (3) tick();
    Rst = 0;
    settle();
    check("rst_stall", 128'(CoreStall), 128'h0);
    check("rst_memreq", 128'(MemReq), 128'h0);
    check("rst_err", 128'(AccessErr), 128'h0);
    tick();

    // Core-only read
    CoreReqQ103H = mk(0, 1, 32'h0001_0010, 32'h0);
    settle();
    check("cr_stall", 128'(CoreStall), 128'h0);
    check("cr_rden",  128'(MemReq.RdEn), 128'h1);
    tick();
    CoreReqQ103H = '0; MemRdData = 32'hDEADBEEF;
    settle();
    check("cr_valid", 128'(CoreRdValidQ104H), 128'h1);
    check("cr_data",  128'(CoreRdDataQ104H), 128'hDEADBEEF);
    check("cr_ext_v", 128'(ExtRdValid), 128'h0);
    tick();

    // Alternating reads: core then ext
    CoreReqQ103H = mk(0, 1, 32'h0001_0020, 32'h0);
    settle(); tick();
    CoreReqQ103H = '0; ExtReqValid = 1; ExtReq = mk(0, 1, 32'h0001_0030, 32'h0);
    MemRdData = 32'h11;
    settle();
    check("alt_core_d", 128'(CoreRdDataQ104H), 128'h11);
    check("alt_ext_rdy", 128'(ExtReady), 128'h1);
    tick();
    ExtReqValid = 0; ExtReq = '0; MemRdData = 32'h22;
    settle();
    check("alt_ext_v", 128'(ExtRdValid), 128'h1);
    check("alt_ext_d", 128'(ExtRdData), 128'h22);
    check("alt_core_hold", 128'(CoreRdDataQ104H), 128'h11);
    tick();

    // Starvation: period of 5, then a locked ext burst while core waits
    CoreReqQ103H = mk(1, 0, 32'h0001_0040, 32'hC0DE);
    ExtReqValid = 1; ExtReq = mk(1, 0, 32'h0001_0100, 32'h0);
    for (int i = 0; i < 14; i++) begin
      if (i == 5) ExtReq = mk(1, 0, 32'h0001_0104, 32'h1);
      if (i == 10) begin ExtReq = mk(1, 0, 32'h0001_0000, 32'hA0); ExtLock = 1; end
      MemRdData = $urandom;
      settle();
      check("starve_stall", 128'(CoreStall), 128'(i % 5 == 4));
      check("starve_rdy",   128'(ExtReady),  128'(i % 5 == 4));
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      ExtReq = mk(1, 0, 32'h0001_0000 + 32'(4 * k), 32'hA0 + 32'(k));
      settle();
      check("lock_stall", 128'(CoreStall), 128'h1);
      check("lock_addr",  128'(MemReq.Address), 128'(32'h0001_0000 + 32'(4 * k)));
      tick();
    end
    ExtReqValid = 0; ExtLock = 0; ExtReq = '0;
    settle();
    check("unlock_stall", 128'(CoreStall), 128'h0);
    check("unlock_addr",  128'(MemReq.Address), 128'h0001_0040);
    tick();

    // Out-of-region reads
    CoreReqQ103H = mk(0, 1, 32'h0002_0000, 32'h0);
    settle();
    check("oor_rden",  128'(MemReq.RdEn), 128'h0);
    check("oor_stall", 128'(CoreStall), 128'h0);
    tick();
    CoreReqQ103H = mk(0, 1, 32'h0003_0000, 32'h0); MemRdData = 32'h55;
    settle();
    check("oor_err",   128'(AccessErr), 128'h1);
    check("oor_addr",  128'(ErrAddr), 128'h0002_0000);
    check("oor_rd_v",  128'(CoreRdValidQ104H), 128'h1);
    check("oor_rd_d",  128'(CoreRdDataQ104H), 128'h0);
    tick();
    CoreReqQ103H = '0;
    settle();
    check("oor_addr2", 128'(ErrAddr), 128'h0002_0000);
    tick();

    // Reset while a read is in flight
    CoreReqQ103H = mk(0, 1, 32'h0001_0050, 32'h0); Rst = 1;
    settle(); tick();
    Rst = 0; CoreReqQ103H = '0; MemRdData = 32'h99;
    settle();
    check("rstrd_core_v", 128'(CoreRdValidQ104H), 128'h0);
    check("rstrd_ext_v",  128'(ExtRdValid), 128'h0);
    check("rstrd_err",    128'(AccessErr), 128'h0);
    check("rstrd_state",  128'(dut.state), 128'(ARB_CORE));
    tick();

    // Random traffic; requesters hold while they are not served
    for (int n = 0; n < 1500; n++) begin
      core_hold = (CoreReqQ103H.WrEn | CoreReqQ103H.RdEn) && (m_win != W_CORE);
      ext_hold  = ExtReqValid && (m_win != W_EXT);
      if (!core_hold) begin
        case ($urandom_range(0, 7))
          0, 1, 2: CoreReqQ103H = '0;
          3, 4:    CoreReqQ103H = mk(0, 1, rand_addr(), 32'h0);
          5, 6:    CoreReqQ103H = mk(1, 0, rand_addr(), $urandom);
          default: CoreReqQ103H = mk(1, 1, rand_addr(), $urandom);
        endcase
      end
      if (!ext_hold) begin
        ExtReqValid = ($urandom_range(0, 2) != 0);
        ExtReq = mk(1'($urandom), 1'($urandom), rand_addr(), $urandom);
      end
      if ($urandom_range(0, 5) == 0) ExtLock = ~ExtLock;
      Rst = ($urandom_range(0, 99) == 0);
      MemRdData = $urandom;
      settle();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
